// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// A 20-bit input becomes six packed BCD digits; inputs above 999999 saturate.

module bin_to_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 20,
  parameter int NDIG      = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          bcd_out,
  output logic                 overflow
);
  localparam int SW = 4 * NDIG;
  localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(999999);
  localparam logic [4:0]           LAST    = 5'(BIN_WIDTH);
  localparam logic [31:0]          SAT     = 32'h0099_9999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] sr;
  logic [SW-1:0]        scratch, adj;
  logic [4:0]           cnt;
  logic                 ovf_lat;

  // Per-digit add-3 correction; digits are independent, no carry between them.
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bin_to_bcd_add3 u_add3 (.d(scratch[4*g +: 4]), .q(adj[4*g +: 4]));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // SHIFT spends one extra cycle after the last step so the result lands on DONE entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sr       <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_lat  <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          sr      <= bin_in;
          scratch <= '0;
          cnt     <= '0;
          ovf_lat <= (bin_in > MAX_VAL);
        end
        SHIFT: if (cnt != LAST) begin
          {scratch, sr} <= {adj[SW-2:0], sr, 1'b0};
          cnt           <= cnt + 5'd1;
        end else begin
          bcd_out  <= ovf_lat ? SAT : 32'(scratch);
          overflow <= ovf_lat;
        end
        default: ;
      endcase
    end
  end
endmodule
